// File: rtl/m_mem_arbiter_pkg.sv
// Shared encodings for the DRAM port arbiter: FSM states and owner codes.
package m_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_PW   = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_DMA  = 2'd3;

endpackage

// File: rtl/m_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick between CPU and DMA; rr=1 means DMA is preferred.
module m_rr_pick2 (
  input  logic cpu_req,
  input  logic dma_req,
  input  logic rr,
  output logic vld,
  output logic pick_dma,
  output logic rr_nxt
);

  always_comb begin
    vld      = cpu_req | dma_req;
    pick_dma = dma_req & (~cpu_req | rr);
    // the loser of this grant becomes the preferred one next time
    rr_nxt   = vld ? ~pick_dma : rr;
  end

endmodule

// File: rtl/m_mem_arbiter.sv
// Single DRAM port arbiter for page walker, CPU and DMA; one transaction at a time,
// page walker has absolute priority and can lock out the others.
module m_mem_arbiter
  import m_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              w_pw_req,
  input  logic              w_pw_we,
  input  logic [ADDR_W-1:0] w_pw_addr,
  input  logic [DATA_W-1:0] w_pw_wdata,
  input  logic              w_pw_lock,
  input  logic              w_cpu_req,
  input  logic              w_cpu_we,
  input  logic [ADDR_W-1:0] w_cpu_addr,
  input  logic [DATA_W-1:0] w_cpu_wdata,
  input  logic              w_dma_req,
  input  logic              w_dma_we,
  input  logic [ADDR_W-1:0] w_dma_addr,
  input  logic [DATA_W-1:0] w_dma_wdata,
  output logic              w_pw_done,
  output logic              w_cpu_done,
  output logic              w_dma_done,
  output logic [DATA_W-1:0] w_rdata,
  output logic              w_err,
  output logic [1:0]        w_owner,
  output logic              w_mem_req,
  output logic              w_mem_we,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic [DATA_W-1:0] w_mem_wdata,
  input  logic              w_dram_busy,
  input  logic [DATA_W-1:0] w_dram_odata
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              rr_q, rr_d;
  logic [1:0]        owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [2:0]        done_q, done_d;

  logic pick_vld, pick_dma, rr_nxt;

  m_rr_pick2 u_pick (
    .cpu_req  (w_cpu_req),
    .dma_req  (w_dma_req),
    .rr       (rr_q),
    .vld      (pick_vld),
    .pick_dma (pick_dma),
    .rr_nxt   (rr_nxt)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    mem_req_d = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    done_d    = 3'b000;
    unique case (state_q)
      ARB_IDLE: begin
        if (w_pw_req) begin
          owner_d   = OWN_PW;
          we_d      = w_pw_we;
          addr_d    = w_pw_addr;
          wdata_d   = w_pw_wdata;
          mem_req_d = 1'b1;
          state_d   = ARB_ISSUE;
        end else if (!w_pw_lock && pick_vld) begin
          owner_d   = pick_dma ? OWN_DMA : OWN_CPU;
          we_d      = pick_dma ? w_dma_we    : w_cpu_we;
          addr_d    = pick_dma ? w_dma_addr  : w_cpu_addr;
          wdata_d   = pick_dma ? w_dma_wdata : w_cpu_wdata;
          rr_d      = rr_nxt;
          mem_req_d = 1'b1;
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        // cnt_q == 0 marks the guard cycle where busy has not risen yet
        if (cnt_q != '0 && !w_dram_busy) begin
          rdata_d = w_dram_odata;
          err_d   = 1'b0;
          done_d  = {owner_q == OWN_DMA, owner_q == OWN_CPU, owner_q == OWN_PW};
          state_d = ARB_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          done_d  = {owner_q == OWN_DMA, owner_q == OWN_CPU, owner_q == OWN_PW};
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_DONE: begin
        owner_d = OWN_NONE;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ARB_IDLE;
      rr_q      <= 1'b0;
      owner_q   <= OWN_NONE;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      mem_req_q <= mem_req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign w_pw_done   = done_q[0];
  assign w_cpu_done  = done_q[1];
  assign w_dma_done  = done_q[2];
  assign w_rdata     = rdata_q;
  assign w_err       = err_q;
  assign w_owner     = owner_q;
  assign w_mem_req   = mem_req_q;
  assign w_mem_we    = we_q;
  assign w_mem_addr  = addr_q;
  assign w_mem_wdata = wdata_q;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter with a small busy-countdown DRAM responder.
module tb_m_mem_arbiter;

  logic        CLK, RST;
  logic        w_pw_req, w_pw_we, w_pw_lock;
  logic [31:0] w_pw_addr, w_pw_wdata;
  logic        w_cpu_req, w_cpu_we;
  logic [31:0] w_cpu_addr, w_cpu_wdata;
  logic        w_dma_req, w_dma_we;
  logic [31:0] w_dma_addr, w_dma_wdata;
  logic        w_pw_done, w_cpu_done, w_dma_done;
  logic [31:0] w_rdata;
  logic        w_err;
  logic [1:0]  w_owner;
  logic        w_mem_req, w_mem_we;
  logic [31:0] w_mem_addr, w_mem_wdata;
  logic        w_dram_busy;
  logic [31:0] w_dram_odata;

  int errors = 0;
  int checks = 0;
  int busy_len;
  int bcnt;
  logic busy_force;

  m_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .w_pw_req(w_pw_req), .w_pw_we(w_pw_we), .w_pw_addr(w_pw_addr), .w_pw_wdata(w_pw_wdata),
    .w_pw_lock(w_pw_lock),
    .w_cpu_req(w_cpu_req), .w_cpu_we(w_cpu_we), .w_cpu_addr(w_cpu_addr), .w_cpu_wdata(w_cpu_wdata),
    .w_dma_req(w_dma_req), .w_dma_we(w_dma_we), .w_dma_addr(w_dma_addr), .w_dma_wdata(w_dma_wdata),
    .w_pw_done(w_pw_done), .w_cpu_done(w_cpu_done), .w_dma_done(w_dma_done),
    .w_rdata(w_rdata), .w_err(w_err), .w_owner(w_owner),
    .w_mem_req(w_mem_req), .w_mem_we(w_mem_we), .w_mem_addr(w_mem_addr), .w_mem_wdata(w_mem_wdata),
    .w_dram_busy(w_dram_busy), .w_dram_odata(w_dram_odata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DRAM responder: busy for busy_len cycles starting the cycle after the issue strobe
  always @(posedge CLK) begin
    if (RST) bcnt <= 0;
    else if (w_mem_req) bcnt <= busy_len;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign w_dram_busy = busy_force | (bcnt != 0);

  // Steps negedges until a done pulse; k counts negedges from the call (t = call cycle).
  task automatic run_txn(input bit drop, output int k, output logic [2:0] who, output int nreq);
    k = 0; who = 3'b000; nreq = 0;
    while (who == 3'b000 && k < 40) begin
      @(negedge CLK);
      k++;
      if (w_mem_req) nreq++;
      who = {w_dma_done, w_cpu_done, w_pw_done};
      if (drop && k == 1) begin w_pw_req = 0; w_cpu_req = 0; w_dma_req = 0; end
    end
    checks++;
    if (who == 3'b000) begin errors++; $display("FAIL txn_wait: no done pulse within %0d cycles", k); end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    w_pw_req = 0; w_pw_we = 0; w_pw_addr = 0; w_pw_wdata = 0; w_pw_lock = 0;
    w_cpu_req = 0; w_cpu_we = 0; w_cpu_addr = 0; w_cpu_wdata = 0;
    w_dma_req = 0; w_dma_we = 0; w_dma_addr = 0; w_dma_wdata = 0;
    busy_len = 0; busy_force = 0; w_dram_odata = 0;
    do_reset();
    checks++;
    if ({w_pw_done, w_cpu_done, w_dma_done, w_err, w_mem_req, w_mem_we} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
                        {w_pw_done, w_cpu_done, w_dma_done, w_err, w_mem_req, w_mem_we});
    end
    checks++;
    if (w_owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", w_owner); end
    checks++;
    if ({w_rdata, w_mem_addr, w_mem_wdata} !== 96'd0) begin
      errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", w_rdata, w_mem_addr, w_mem_wdata);
    end
  endtask

  task automatic test_cpu_read();
    int k, n; logic [2:0] who;
    busy_len = 3; w_dram_odata = 32'hDEADBEEF;
    w_cpu_req = 1; w_cpu_we = 0; w_cpu_addr = 32'h8000_0100;
    @(negedge CLK);
    checks++;
    if (!(w_mem_req === 1'b1 && w_mem_addr === 32'h8000_0100 && w_owner === 2'd2)) begin
      errors++; $display("FAIL cpu_issue: req=%b addr=%h owner=%0d want 1 80000100 2", w_mem_req, w_mem_addr, w_owner);
    end
    run_txn(0, k, who, n);
    k++; n++;  // account for the ISSUE cycle stepped above
    checks++;
    if (who !== 3'b010 || k != 6) begin errors++; $display("FAIL cpu_done: who=%b k=%0d want 010 6", who, k); end
    checks++;
    if (w_rdata !== 32'hDEADBEEF || w_err !== 1'b0) begin
      errors++; $display("FAIL cpu_rdata: rdata=%h err=%b want deadbeef 0", w_rdata, w_err);
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL cpu_memreq_count: got %0d want 1", n); end
    w_cpu_req = 0;
    @(negedge CLK);
    checks++;
    if (w_owner !== 2'd0) begin errors++; $display("FAIL cpu_owner_clear: got %0d want 0", w_owner); end
  endtask

  task automatic test_priority();
    int k, n; logic [2:0] who;
    do_reset();
    busy_len = 1;
    w_pw_req = 1; w_pw_addr = 32'hA1; w_cpu_req = 1; w_cpu_addr = 32'hA2; w_dma_req = 1; w_dma_addr = 32'hA3;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b001 || w_mem_addr !== 32'hA1 || k != 4) begin
      errors++; $display("FAIL prio_pw: who=%b addr=%h k=%0d want 001 a1 4", who, w_mem_addr, k);
    end
    w_pw_req = 0;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b010 || w_mem_addr !== 32'hA2 || k != 5) begin
      errors++; $display("FAIL prio_cpu: who=%b addr=%h k=%0d want 010 a2 5", who, w_mem_addr, k);
    end
    w_cpu_addr = 32'hA4;  // CPU re-requests; rr now prefers DMA
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b100 || w_mem_addr !== 32'hA3) begin
      errors++; $display("FAIL prio_rr_dma: who=%b addr=%h want 100 a3", who, w_mem_addr);
    end
    w_dma_req = 0;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b010 || w_mem_addr !== 32'hA4) begin
      errors++; $display("FAIL prio_rr_cpu: who=%b addr=%h want 010 a4", who, w_mem_addr);
    end
    w_cpu_req = 0;
    @(negedge CLK);
  endtask

  task automatic test_lock();
    int k, n; logic [2:0] who;
    busy_len = 2;
    w_pw_lock = 1; w_pw_req = 1; w_pw_we = 0; w_pw_addr = 32'hB000_0010;
    w_cpu_req = 1; w_cpu_addr = 32'hC0;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b001 || w_mem_we !== 1'b0) begin errors++; $display("FAIL lock_pw1: who=%b we=%b want 001 0", who, w_mem_we); end
    w_pw_addr = 32'hB000_0020;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b001 || w_mem_addr !== 32'hB000_0020) begin
      errors++; $display("FAIL lock_pw2: who=%b addr=%h want 001 b0000020", who, w_mem_addr);
    end
    w_pw_we = 1; w_pw_wdata = 32'h0000_00C1; w_pw_addr = 32'hB000_0030;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b001 || w_mem_we !== 1'b1 || w_mem_wdata !== 32'hC1 || w_mem_addr !== 32'hB000_0030) begin
      errors++; $display("FAIL lock_pw3_write: who=%b we=%b wdata=%h addr=%h want 001 1 c1 b0000030",
                        who, w_mem_we, w_mem_wdata, w_mem_addr);
    end
    w_pw_req = 0; w_pw_we = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (w_owner !== 2'd0 || w_mem_req !== 1'b0) begin
        errors++; $display("FAIL lock_blocks_cpu: cycle %0d owner=%0d req=%b want 0 0", i, w_owner, w_mem_req);
      end
    end
    w_pw_lock = 0;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b010 || w_mem_addr !== 32'hC0) begin
      errors++; $display("FAIL lock_release_cpu: who=%b addr=%h want 010 c0", who, w_mem_addr);
    end
    w_cpu_req = 0;
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    int k, n; logic [2:0] who;
    busy_len = 0; busy_force = 1; w_dram_odata = 32'h1234_5678;
    w_cpu_req = 1; w_cpu_addr = 32'hD00;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b010 || k != 10) begin errors++; $display("FAIL timeout_latency: who=%b k=%0d want 010 10", who, k); end
    checks++;
    if (w_err !== 1'b1 || w_rdata !== 32'd0) begin
      errors++; $display("FAIL timeout_err: err=%b rdata=%h want 1 0", w_err, w_rdata);
    end
    w_cpu_req = 0; busy_force = 0;
    @(negedge CLK);
    // busy falls on the last cycle before the limit: normal completion
    busy_len = 7; w_cpu_req = 1;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b010 || k != 10 || w_err !== 1'b0 || w_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL timeout_edge: who=%b k=%0d err=%b rdata=%h want 010 10 0 12345678",
                        who, k, w_err, w_rdata);
    end
    w_cpu_req = 0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_wait();
    int k, n; logic [2:0] who;
    busy_len = 5; w_dma_req = 1; w_dma_addr = 32'hE1;
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    checks++;
    if (w_owner !== 2'd3) begin errors++; $display("FAIL rst_wait_owner: got %0d want 3", w_owner); end
    RST = 1;
    @(negedge CLK);
    checks++;
    if ({w_pw_done, w_cpu_done, w_dma_done, w_err, w_mem_req, w_mem_we, w_owner} !== 8'd0 ||
        {w_rdata, w_mem_addr, w_mem_wdata} !== 96'd0) begin
      errors++; $display("FAIL rst_wait_outputs: owner=%0d dma_done=%b addr=%h rdata=%h want all 0",
                        w_owner, w_dma_done, w_mem_addr, w_rdata);
    end
    RST = 0; busy_len = 0; w_dma_addr = 32'hE2;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b100 || k != 4 || w_mem_addr !== 32'hE2) begin
      errors++; $display("FAIL rst_wait_followup: who=%b k=%0d addr=%h want 100 4 e2", who, k, w_mem_addr);
    end
    w_dma_req = 0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int k, n; logic [2:0] who;
    busy_len = 1; w_cpu_req = 1; w_cpu_addr = 32'hF1;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b010 || k != 4) begin errors++; $display("FAIL b2b_first: who=%b k=%0d want 010 4", who, k); end
    w_cpu_addr = 32'hF2;
    run_txn(0, k, who, n);
    checks++;
    if (who !== 3'b010 || k != 5 || w_mem_addr !== 32'hF2) begin
      errors++; $display("FAIL b2b_second: who=%b k=%0d addr=%h want 010 5 f2", who, k, w_mem_addr);
    end
    w_cpu_req = 0;
    @(negedge CLK);
    // request dropped right after grant still completes with a done pulse
    w_dma_req = 1; w_dma_addr = 32'hF3;
    run_txn(1, k, who, n);
    checks++;
    if (who !== 3'b100 || k != 4) begin errors++; $display("FAIL b2b_dropped_req: who=%b k=%0d want 100 4", who, k); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_priority();
    test_lock();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
